core_mem_arbiter: RTL and testbench

CORE_MEM_ARBITER -- requirements
Module: core_mem_arbiter

---
 rtl/core_mem_arbiter.sv | 99 +++++++++
 tb/tb_core_mem_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_arbiter.sv
// Two-requester (fetch/LSU) arbiter onto a single shared memory bus.
// Optional macro CORE_MEM_ARB_RR_EN selects round-robin contention instead of dmem priority with starvation guard.
module core_mem_arbiter #(
  parameter int MEM_ADDR_R   = 31,
  parameter int MEM_DATA_R   = 31,
  parameter int MEM_STRB_R   = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  g_clk,
  input  logic                  g_reset,
  input  logic                  imem_req,
  input  logic [MEM_ADDR_R:0]   imem_addr,
  output logic                  imem_gnt,
  output logic                  imem_err,
  output logic [MEM_DATA_R:0]   imem_rdata,
  input  logic                  dmem_req,
  input  logic [MEM_ADDR_R:0]   dmem_addr,
  input  logic                  dmem_wen,
  input  logic [MEM_STRB_R:0]   dmem_strb,
  input  logic [MEM_DATA_R:0]   dmem_wdata,
  output logic                  dmem_gnt,
  output logic                  dmem_err,
  output logic [MEM_DATA_R:0]   dmem_rdata,
  output logic                  mem_req,
  output logic [MEM_ADDR_R:0]   mem_addr,
  output logic                  mem_wen,
  output logic [MEM_STRB_R:0]   mem_strb,
  output logic [MEM_DATA_R:0]   mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_err,
  input  logic [MEM_DATA_R:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} state_t;

  state_t state, state_nxt, st_eff;
  logic   own_i, own_d;
  logic   d_first;

`ifdef CORE_MEM_ARB_RR_EN
  // 1: imem was served by the last completed transaction, so dmem goes next
  logic last_i;

  always_ff @(posedge g_clk) begin
    if (g_reset)                 last_i <= 1'b1;
    else if (mem_req && mem_gnt) last_i <= own_i;
  end

  always_comb d_first = g_reset ? 1'b1 : last_i;
`else
  localparam logic [3:0] STARVE_LIM4 = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;

  always_ff @(posedge g_clk) begin
    if (g_reset)                              starve_cnt <= '0;
    else if (imem_gnt)                        starve_cnt <= '0;
    else if (imem_req && starve_cnt != 4'hF)  starve_cnt <= starve_cnt + 4'd1;
  end

  always_comb d_first = g_reset ? 1'b1 : (starve_cnt < STARVE_LIM4);
`endif

  always_ff @(posedge g_clk) begin
    if (g_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Reset forces IDLE arbitration on the outputs without waiting for the state register.
  always_comb begin
    st_eff    = g_reset ? IDLE : state;
    own_i     = 1'b0;
    own_d     = 1'b0;
    case (st_eff)
      LOCK_I: own_i = imem_req;
      LOCK_D: own_d = dmem_req;
      default: begin
        own_d = dmem_req && (!imem_req || d_first);
        own_i = imem_req && !own_d;
      end
    endcase
    state_nxt = IDLE;
    if ((own_i || own_d) && !mem_gnt) state_nxt = own_d ? LOCK_D : LOCK_I;
  end

  always_comb begin
    mem_req    = own_i || own_d;
    mem_addr   = own_d ? dmem_addr : (own_i ? imem_addr : '0);
    mem_wen    = own_d && dmem_wen;
    mem_strb   = own_d ? dmem_strb  : '0;
    mem_wdata  = own_d ? dmem_wdata : '0;
    imem_gnt   = !g_reset && own_i && mem_gnt;
    imem_err   = !g_reset && own_i && mem_err;
    dmem_gnt   = !g_reset && own_d && mem_gnt;
    dmem_err   = !g_reset && own_d && mem_err;
    imem_rdata = mem_rdata;
    dmem_rdata = mem_rdata;
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed scenarios followed by protocol-respecting random traffic checked against a transaction-level model.
module tb_core_mem_arbiter;
  localparam int LIM = 4;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        imem_req, dmem_req, dmem_wen, mem_gnt, mem_err;
  logic [31:0] imem_addr, dmem_addr, dmem_wdata, mem_rdata;
  logic [3:0]  dmem_strb;
  logic        imem_gnt, imem_err, dmem_gnt, dmem_err, mem_req, mem_wen;
  logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_strb;

  int passed = 0, failed = 0, total = 0;

  // reference model: who holds the bus (0 nobody, 1 fetch, 2 LSU), starvation age, last server
  int mdl_lock, mdl_cnt, win;
  bit mdl_last_i, d_first;
  bit i_pend, d_pend;
  logic e_ig, e_dg;

  always #5 g_clk = ~g_clk;

  core_mem_arbiter #(.MEM_ADDR_R(31), .MEM_DATA_R(31), .MEM_STRB_R(3), .STARVE_LIMIT(LIM)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_err(imem_err),
    .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_err(dmem_err), .dmem_rdata(dmem_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_err(mem_err), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr, input logic [31:0] da,
                        input logic dw, input logic [3:0] ds, input logic [31:0] dd,
                        input logic mg, input logic me, input logic [31:0] rd);
    imem_req = ir; imem_addr = ia;
    dmem_req = dr; dmem_addr = da; dmem_wen = dw; dmem_strb = ds; dmem_wdata = dd;
    mem_gnt = mg; mem_err = me; mem_rdata = rd;
  endtask

  task automatic next_cyc();
    @(posedge g_clk);
    #1;
  endtask

  task automatic rst_cycle();
    g_reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    next_cyc();
    g_reset = 1'b0;
  endtask

  initial begin
    g_reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge g_clk);
    #1;
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_gnts", 64'({imem_gnt, dmem_gnt, imem_err, dmem_err}), 64'(0));
    g_reset = 1'b0;

    // lone fetch, granted in the same cycle
    set_in(1, 32'h100, 0, 0, 0, 0, 0, 1, 0, 32'h55);
    #1;
    chk("single_i_req", 64'(mem_req), 64'(1));
    chk("single_i_addr", 64'(mem_addr), 64'(32'h100));
    chk("single_i_gnt", 64'({imem_gnt, dmem_gnt}), 64'(2'b10));
    chk("single_i_wen", 64'({mem_wen, mem_strb, mem_wdata}), 64'(0));
    next_cyc();
    set_in(0, 0, 1, 32'h300, 0, 0, 0, 0, 0, 0);
    #1;
    chk("idle_after_gnt", 64'(mem_addr), 64'(32'h300));
    next_cyc();
    rst_cycle();

    // contention right after reset, memory responds on the third cycle
    for (int k = 1; k <= 4; k++) begin
      if (k <= 3) set_in(1, 32'h200, 1, 32'h300, 1, 4'hF, 32'hDEADBEEF, k == 3, 0, 0);
      else        set_in(1, 32'h200, 0, 0, 0, 0, 0, 1, 0, 0);
      #1;
      if (k <= 3) begin
        chk("lockd_addr", 64'(mem_addr), 64'(32'h300));
        chk("lockd_wdata", 64'({mem_wen, mem_strb, mem_wdata}), 64'({1'b1, 4'hF, 32'hDEADBEEF}));
        chk("lockd_gnt", 64'({imem_gnt, dmem_gnt}), 64'({1'b0, k == 3}));
      end else begin
        chk("i_after_d_addr", 64'(mem_addr), 64'(32'h200));
        chk("i_after_d_gnt", 64'({imem_gnt, dmem_gnt, mem_wen}), 64'(3'b100));
      end
      next_cyc();
    end

    // fetch locks the bus, LSU arrives meanwhile, fetch completes with an error
    set_in(1, 32'h440, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("locki_start", 64'(mem_addr), 64'(32'h440));
    next_cyc();
    set_in(1, 32'h440, 1, 32'h550, 1, 4'h3, 32'hA5A5, 0, 0, 0);
    #1;
    chk("locki_frozen", 64'({mem_addr, mem_wen}), 64'({32'h440, 1'b0}));
    next_cyc();
    set_in(1, 32'h440, 1, 32'h550, 1, 4'h3, 32'hA5A5, 1, 1, 32'h12345678);
    #1;
    chk("locki_err", 64'({imem_gnt, imem_err, dmem_gnt, dmem_err}), 64'(4'b1100));
    chk("rdata_bcast", {imem_rdata, dmem_rdata}, {32'h12345678, 32'h12345678});
    next_cyc();
    set_in(0, 0, 1, 32'h550, 1, 4'h3, 32'hA5A5, 0, 0, 0);
    #1;
    chk("rearb_next_cyc", 64'(mem_addr), 64'(32'h550));
    next_cyc();

    // LSU abandons its locked request
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("drop_mem_req", 64'({mem_req, mem_addr}), 64'(0));
    next_cyc();
    set_in(1, 32'h660, 0, 0, 0, 0, 0, 1, 0, 0);
    #1;
    chk("drop_back_idle", 64'({imem_gnt, mem_addr}), 64'({1'b1, 32'h660}));
    next_cyc();
    rst_cycle();

    // sustained contention with single-cycle memory
    for (int k = 0; k < 10; k++) begin
      bit ei;
`ifdef CORE_MEM_ARB_RR_EN
      ei = (k % 2) == 1;
`else
      ei = (k % (LIM + 1)) == LIM;
`endif
      set_in(1, 32'h700, 1, 32'h800 + 32'(k), 0, 0, 0, 1, 0, 0);
      #1;
      chk("contend_gnt", 64'({imem_gnt, dmem_gnt}), 64'({ei, !ei}));
      chk("contend_addr", 64'(mem_addr), ei ? 64'(32'h700) : 64'(32'h800 + 32'(k)));
      next_cyc();
    end
    rst_cycle();

    // reset pulsed while the LSU holds the bus
    for (int k = 0; k < 5; k++) begin
      set_in(1, 32'h900, 1, 32'hA00, 0, 0, 0, 0, 0, 0);
      #1;
      chk("pre_rst_lockd", 64'(mem_addr), 64'(32'hA00));
      next_cyc();
    end
    g_reset = 1'b1;
    set_in(1, 32'h900, 1, 32'hA00, 0, 0, 0, 1, 0, 0);
    #1;
    chk("rst_no_gnt", 64'({imem_gnt, dmem_gnt, mem_req}), 64'(3'b001));
    next_cyc();
    g_reset = 1'b0;
    #1;
    chk("post_rst_d_wins", 64'({imem_gnt, dmem_gnt, mem_addr}), 64'({2'b01, 32'hA00}));
    next_cyc();
    set_in(1, 32'h900, 0, 0, 0, 0, 0, 1, 0, 0);
    next_cyc();
    rst_cycle();

    // random traffic against the model
    mdl_lock = 0; mdl_cnt = 0; mdl_last_i = 1'b1;
    i_pend = 1'b0; d_pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic [3:0]  e_strb;
      logic [31:0] e_addr, e_wdata;
      if (!i_pend && ($urandom % 3 != 0)) begin
        i_pend = 1'b1; imem_addr = $urandom;
      end
      if (!d_pend && ($urandom % 3 != 0)) begin
        d_pend = 1'b1; dmem_addr = $urandom; dmem_wen = 1'($urandom);
        dmem_strb = 4'($urandom); dmem_wdata = $urandom;
      end
      imem_req = i_pend; dmem_req = d_pend;
      mem_gnt = 1'($urandom); mem_err = ($urandom % 4) == 0; mem_rdata = $urandom;
      g_reset = ($urandom % 40) == 0;

`ifdef CORE_MEM_ARB_RR_EN
      d_first = g_reset ? 1'b1 : mdl_last_i;
`else
      d_first = g_reset ? 1'b1 : (mdl_cnt < LIM);
`endif
      if (g_reset || mdl_lock == 0) begin
        if (imem_req && dmem_req) win = d_first ? 2 : 1;
        else                      win = imem_req ? 1 : (dmem_req ? 2 : 0);
      end else if (mdl_lock == 1) win = imem_req ? 1 : 0;
      else                        win = dmem_req ? 2 : 0;

      e_addr  = (win == 2) ? dmem_addr : ((win == 1) ? imem_addr : 32'h0);
      e_strb  = (win == 2) ? dmem_strb : 4'h0;
      e_wdata = (win == 2) ? dmem_wdata : 32'h0;
      e_ig    = !g_reset && win == 1 && mem_gnt;
      e_dg    = !g_reset && win == 2 && mem_gnt;
      #1;
      chk("rnd_ctrl", 64'({mem_req, mem_wen, mem_strb, imem_gnt, imem_err, dmem_gnt, dmem_err}),
          64'({win != 0, win == 2 && dmem_wen, e_strb, e_ig, !g_reset && win == 1 && mem_err,
               e_dg, !g_reset && win == 2 && mem_err}));
      chk("rnd_addr", 64'(mem_addr), 64'(e_addr));
      chk("rnd_wdata", 64'(mem_wdata), 64'(e_wdata));
      chk("rnd_rdata", {imem_rdata, dmem_rdata}, {mem_rdata, mem_rdata});

      if (g_reset) begin
        mdl_lock = 0; mdl_cnt = 0; mdl_last_i = 1'b1;
      end else begin
        mdl_lock = (win != 0 && !mem_gnt) ? win : 0;
        if (e_ig)                         mdl_cnt = 0;
        else if (imem_req && mdl_cnt < 15) mdl_cnt++;
        if (win != 0 && mem_gnt) mdl_last_i = (win == 1);
      end
      if (e_ig) i_pend = 1'b0;
      if (e_dg) d_pend = 1'b0;
      next_cyc();
    end
    g_reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
